// File: rtl/fork_dispatcher_pkg.sv
// Shared definitions for the fork dispatcher: inter-CPU message codes
// and the default address/data widths used across the CPU cluster.
package fork_dispatcher_pkg;

    // Default sizes shared with the rest of the cluster
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Inter-CPU message codes
    localparam logic [7:0] CPU_R_FORK_THRD = 8'h21;
    localparam logic [7:0] CPU_R_FORK_DONE = 8'h22;
    localparam logic [7:0] CPU_R_STOP_THRD = 8'h23;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO. A push while full is dropped (full is
// judged before any pop in the same cycle); a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];
    assign count   = count_q;

    // Entry storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fork_dispatcher.sv
// Fork dispatcher: accepts thread-fork requests from the thread controller,
// acknowledges them with FORK_DONE, queues them, and hands each queued
// thread to an idle CPU chosen round-robin via a start/ack handshake.
module fork_dispatcher
    import fork_dispatcher_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 4,
    parameter int NUM_CPU = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             req_msg,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_data,
    output logic                   disp_online,
    output logic [7:0]             ack_msg,
    input  logic [NUM_CPU-1:0]     cpu_idle,
    output logic [NUM_CPU-1:0]     start,
    output logic [ADDR_W-1:0]      start_addr,
    output logic [DATA_W-1:0]      start_data,
    input  logic [NUM_CPU-1:0]     start_ack,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   err_overflow
);
    localparam int ENTRY_W   = ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int CPU_IDX_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

    typedef enum logic {I_IDLE, I_WAIT}  intake_state_t;
    typedef enum logic {D_IDLE, D_OFFER} disp_state_t;

    intake_state_t          istate_q, istate_d;
    disp_state_t            dstate_q, dstate_d;
    logic [7:0]             req_msg_q;
    logic [7:0]             ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   online_q, online_d;
    logic                   fork_rise;
    logic                   push, pop;
    logic                   fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]     fifo_din, fifo_dout;
    logic [CNT_W-1:0]       fifo_count, count_next;
    logic [NUM_CPU-1:0]     start_q, start_d;
    logic [ADDR_W-1:0]      start_addr_q, start_addr_d;
    logic [DATA_W-1:0]      start_data_q, start_data_d;
    logic [CPU_IDX_W-1:0]   tgt_q, tgt_d;
    logic [CPU_IDX_W-1:0]   rr_q, rr_d;
    logic [CPU_IDX_W-1:0]   sel_idx, cand;
    logic                   sel_found;

    assign fifo_din  = {req_addr, req_data};
    assign fork_rise = (req_msg == CPU_R_FORK_THRD) && (req_msg_q != CPU_R_FORK_THRD);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Intake state, message history, ack pulse and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            istate_q  <= I_IDLE;
            req_msg_q <= 8'h00;
            ack_q     <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            istate_q  <= istate_d;
            req_msg_q <= req_msg;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Intake next state: one accept per fork message, re-armed when it drops
    always_comb begin
        istate_d = istate_q;
        case (istate_q)
            I_IDLE:  if (fork_rise) istate_d = I_WAIT;
            I_WAIT:  if (req_msg != CPU_R_FORK_THRD) istate_d = I_IDLE;
            default: istate_d = I_IDLE;
        endcase
    end

    // Intake outputs: push and acknowledge, or flag overflow when full
    always_comb begin
        push  = 1'b0;
        ack_d = 8'h00;
        err_d = err_q;
        if (istate_q == I_IDLE && fork_rise) begin
            if (!fifo_full) begin
                push  = 1'b1;
                ack_d = CPU_R_FORK_DONE;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Online flag tracks the occupancy that will hold after this edge
    always_comb begin
        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        online_d   = (count_next != CNT_W'(DEPTH));
    end

    // Online flag register; forced low during reset
    always_ff @(posedge clk) begin
        if (rst) begin
            online_q <= 1'b0;
        end else begin
            online_q <= online_d;
        end
    end

    // Round-robin pick: first idle CPU at or after rr_q, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            cand = CPU_IDX_W'((int'(rr_q) + i) % NUM_CPU);
            if (!sel_found && cpu_idle[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Dispatch state, offer registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            dstate_q     <= D_IDLE;
            start_q      <= '0;
            start_addr_q <= '0;
            start_data_q <= '0;
            tgt_q        <= '0;
            rr_q         <= '0;
        end else begin
            dstate_q     <= dstate_d;
            start_q      <= start_d;
            start_addr_q <= start_addr_d;
            start_data_q <= start_data_d;
            tgt_q        <= tgt_d;
            rr_q         <= rr_d;
        end
    end

    // Dispatch next state: offer when work and an idle CPU exist; leave on ack or withdraw
    always_comb begin
        dstate_d = dstate_q;
        case (dstate_q)
            D_IDLE:  if (!fifo_empty && sel_found) dstate_d = D_OFFER;
            D_OFFER: if (start_ack[tgt_q] || !cpu_idle[tgt_q]) dstate_d = D_IDLE;
            default: dstate_d = D_IDLE;
        endcase
    end

    // Dispatch outputs: load the head into the offer, pop on target ack, withdraw if target goes busy
    always_comb begin
        pop          = 1'b0;
        start_d      = start_q;
        start_addr_d = start_addr_q;
        start_data_d = start_data_q;
        tgt_d        = tgt_q;
        rr_d         = rr_q;
        case (dstate_q)
            D_IDLE: begin
                if (!fifo_empty && sel_found) begin
                    start_d      = NUM_CPU'(1) << sel_idx;
                    start_addr_d = fifo_dout[ENTRY_W-1:DATA_W];
                    start_data_d = fifo_dout[DATA_W-1:0];
                    tgt_d        = sel_idx;
                end
            end
            D_OFFER: begin
                if (start_ack[tgt_q]) begin
                    pop     = 1'b1;
                    start_d = '0;
                    rr_d    = (int'(tgt_q) == NUM_CPU - 1) ? '0 : tgt_q + CPU_IDX_W'(1);
                end else if (!cpu_idle[tgt_q]) begin
                    start_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign disp_online  = online_q;
    assign ack_msg      = ack_q;
    assign start        = start_q;
    assign start_addr   = start_addr_q;
    assign start_data   = start_data_q;
    assign pending      = fifo_count;
    assign err_overflow = err_q;

endmodule

// File: doc/fork_dispatcher.md
Name: fork_dispatcher

Overview:
- Dispatcher-side consumer of thread-fork requests issued by a CPU's thread controller on the inter-CPU message bus.
- Accepts a fork request as a start-address plus parameter pair and acknowledges it with the fork-done message.
- Buffers accepted requests in a pending-thread FIFO.
- Hands each pending thread to an idle CPU, chosen round-robin, using a start/ack handshake.

Parameters:
- ADDR_W, 32, width of thread start address.
- DATA_W, 32, width of thread parameter word.
- DEPTH, 4, pending-thread FIFO entries; power of two, at least 2.
- NUM_CPU, 4, number of CPUs that can receive threads; at least 1.

Ports:
- clk, in, 1, clock; all logic on posedge.
- rst, in, 1, reset; synchronous, active-high.
- req_msg, in, 8, inter-CPU message from the requesting thread controller.
- req_addr, in, ADDR_W, new thread start address; valid with the fork message.
- req_data, in, DATA_W, thread parameter; 0 means none.
- disp_online, out, 1, dispatcher can accept a fork request.
- ack_msg, out, 8, reply message; fork-done or 8'h00.
- cpu_idle, in, NUM_CPU, per-CPU idle flag.
- start, out, NUM_CPU, one-hot start offer to the target CPU.
- start_addr, out, ADDR_W, offered thread start address.
- start_data, out, DATA_W, offered thread parameter.
- start_ack, in, NUM_CPU, per-CPU acceptance of the start offer.
- pending, out, clog2(DEPTH)+1, FIFO occupancy.
- err_overflow, out, 1, sticky: a fork request arrived while the FIFO was full.

Behaviour:
- Reset values: disp_online=0, ack_msg=8'h00, start=0, start_addr=0, start_data=0, pending=0, err_overflow=0. FIFO pointers cleared, round-robin pointer set to 0, both FSMs in IDLE.
- Reset mid-operation: all in-flight offers and entries are discarded and no ack is issued.
- disp_online = !rst_seen_this_cycle && (pending != DEPTH); registered.
- Intake FSM states:
  - I_IDLE: rising edge of (req_msg == CPU_R_FORK_THRD), comparing against the previous cycle's registered value, detected at edge N.
    - Not full: push {req_addr, req_data}, set ack_msg = CPU_R_FORK_DONE for exactly one cycle (N+1), go to I_WAIT.
    - Full: no push, no ack, err_overflow<=1, go to I_WAIT.
  - I_WAIT: ack_msg=0; return to I_IDLE once req_msg != CPU_R_FORK_THRD.
  - A fork message held high for many cycles therefore yields one push only.
- Other message codes (e.g. CPU_R_STOP_THRD) are ignored by the intake.
- Dispatch FSM states:
  - D_IDLE: when FIFO non-empty and any cpu_idle is set, select the first idle CPU at or after rr_ptr, wrapping modulo NUM_CPU. Drive start one-hot with the head entry; go to D_OFFER. The earliest offer is the cycle after the push.
  - D_OFFER: hold start and data stable.
    - start_ack[target]=1: pop head, start<=0, rr_ptr<=target+1 (wrapping), go to D_IDLE.
    - cpu_idle[target] drops before ack: withdraw start and go to D_IDLE; the head is retained.
  - start_ack on a non-target CPU is ignored.
- FIFO behaviour:
  - Simultaneous push and pop in one cycle: both happen, pending unchanged.
  - Push when full with a pop in the same cycle: rejected; full is evaluated before the pop.
  - Pointers wrap modulo DEPTH.
  - Order is strictly FIFO.
- Latency: fork message rises at N; ack at N+1; start offer no earlier than N+2.

Decomposition:
- Shared inter-CPU message package holds the message codes: CPU_R_FORK_THRD, CPU_R_FORK_DONE, CPU_R_STOP_THRD.
- Shared sizes package holds the default address and data widths.
- FSM state encodings stay local to this block.
- One sub-module: sync_fifo, parameterised for width and depth. Its width is ADDR_W+DATA_W. Ports: push, pop, din, dout, full, empty, count.

Test Plan:
- Single fork: req_msg=FORK_THRD for 2 cycles with addr=0x100, data=0x20, cpu_idle=4'b0001.
  - Expect ack_msg=FORK_DONE for exactly 1 cycle, then pending=1.
  - Expect start=4'b0001 with start_addr=0x100 and start_data=0x20.
  - After start_ack[0]: pending=0, start=0.
- Fill and overflow: DEPTH=4, cpu_idle=0, issue 5 forks.
  - Expect 4 acks, disp_online=0 after the 4th, no ack on the 5th, err_overflow=1 and sticky.
- Round-robin: 3 pending entries, cpu_idle=4'b1111, each offer acked immediately.
  - Expect targets CPU0, CPU1, CPU2 in order.
  - Expect entries delivered in FIFO order.
- Withdraw: offer to CPU2, drop cpu_idle[2] before ack with all other CPUs busy.
  - Expect start=0 and pending unchanged.
  - Re-raise cpu_idle[2]: expect the same entry re-offered.
- Simultaneous push and pop: FIFO holds 1 entry, start_ack arrives on the same edge a new fork is accepted.
  - Expect pending stays 1; the next offer carries the new entry.
- Reset mid-operation: rst asserted while in D_OFFER with 2 pending.
  - Next cycle expect start=0, pending=0, ack_msg=0, disp_online=0.
  - Cycle after rst deasserts: disp_online=1.
